vga_menu_select: RTL and testbench
==================================

# vga_menu_select

Parametrised menu-selection engine for the VGA front end: N rectangular menu items on the 160×120 quarter-resolution grid, with a cursor moved by controller buttons. It provides edge-detected and auto-repeating navigation, optional wrap-around, 2-D grid movement and a one-cycle confirm pulse. A registered per-pixel highlight flag is produced for the colour mux. It replaces the fixed three-item homescreen selector and sits between the controller interface and the VGA colour output stage.

## Interface
Parameters:
- NUM_ITEMS, 3: menu item count, 2..16.
- COLS, 3: items per grid row; item i is at row i/COLS, column i%COLS.
- WRAP, 1: 1 = wrap at edges, 0 = clamp.
- REPEAT_DELAY, 25_000_000: clk cycles a direction must be held before the first auto-repeat.
- REPEAT_RATE, 10_000_000: clk cycles between subsequent repeats.

Ports (one clock, `clk`; reset `reset` is synchronous and active-high):
- clk, in, 1: 100 MHz system clock.
- reset, in, 1: synchronous active-high reset.
- buttons, in, 8: bit0 up, bit1 down, bit2 left, bit3 right, bit4 confirm, bits 7:5 ignored.
- fsm_en, in, 1: navigation enable.
- item_rects, in, NUM_ITEMS*30: item i at bits [30i+29:30i] = {l[7:0], t[6:0], r[7:0], b[6:0]}; half-open box l≤x<r, t≤y<b.
- pix_en, in, 1: pixel strobe (25 MHz enable).
- x_adj, in, 8: current pixel x (0..159).
- y_adj, in, 7: current pixel y (0..119).
- sel, out, $clog2(NUM_ITEMS): current cursor index.
- confirm, out, 1: one-cycle pulse, sel is valid in the same cycle.
- highlight, out, 1: the pixel is inside the rectangle of item sel.

## Operation
- Reset: sel=0, confirm=0, highlight=0, repeat counter=0, button history=0.
- Edge detect: the history register samples buttons[4:0] every clk, including when fsm_en=0. A button held while enabling does not fire until it is released and pressed again.
- Action selection when fsm_en=1, one per cycle:
  - A confirm rising edge sets confirm=1 and blocks movement that cycle.
  - Otherwise, the direction with a rising edge or a due repeat fires. Priority is up>down>left>right.
- Moves (L = NUM_ITEMS-1):
  - right: sel<L ? sel+1 : (WRAP ? 0 : L).
  - left: sel>0 ? sel-1 : (WRAP ? L : 0).
  - down: sel+COLS≤L ? sel+COLS : (WRAP ? sel%COLS : sel).
  - up: sel≥COLS ? sel-COLS : (WRAP ? the largest index ≤L with the same column : sel).
- Auto-repeat:
  - One counter tracks the highest-priority held direction.
  - It clears on the press edge, on release, and when the tracked direction changes.
  - The first repeat fires when the count reaches REPEAT_DELAY-1; later repeats fire every REPEAT_RATE cycles.
  - Confirm never repeats.
- fsm_en=0: sel is frozen, the counter is cleared, and confirm=0. highlight keeps tracking sel.
- Highlight: on each pix_en cycle, register the hit test of (x_adj, y_adj) against rect[sel]. Hold the value otherwise.
- A rectangle with l≥r or t≥b never hits.

## Timing
- sel updates on the clk edge after the button edge is sampled. Latency from the buttons change to sel change is 2 clk (1 for the history register, 1 for the update).
- confirm is high for exactly 1 clk per press, 2 clk after the button rises.
- highlight is valid 1 clk after the pix_en cycle that presented x/y. The value uses sel as of that cycle.
- A sel change mid-frame takes effect from the next pix_en cycle. No frame synchronisation is done.
- Reset has priority over all events in the same cycle.

## Structure
- Package `menu_pkg`:
  - button bit indices (BTN_UP=0 … BTN_OK=4)
  - RECT_W=30
  - field offsets for l/t/r/b
  - a rectangle-unpack function
- Sub-module `menu_nav_fsm`: edge detection, repeat counter and sel/confirm logic.
- Top level: rectangle mux on sel, hit-test comparators and the highlight register.

## Test plan
Configuration for all scenarios: NUM_ITEMS=5, COLS=3, REPEAT_DELAY=20, REPEAT_RATE=8.
- WRAP=1: right ×5 from reset gives sel 1,2,3,4,0. Then left once gives sel=4.
- WRAP=1, sel=1: up gives sel=4 (column 1, last row). down from sel=4 gives sel=1. down from sel=2 gives sel=2 (wrap to column top).
- WRAP=0, sel=4: right and down leave sel=4. From sel=0, left and up leave sel=0.
- Hold right for 60 clk from sel=0:
  - steps at clk 2, 21, 29, 37, 45, 53 give sel 1,2,3,4,0,1.
  - release then re-press gives exactly one step.
- Press up+right together at sel=4 gives sel=1 (up wins). Confirm+right gives confirm=1 and sel unchanged. Holding confirm gives a single pulse.
- Item 0 at {10,20,15,24} with sel=0:
  - pixel (10,20) gives highlight=1 one clk later.
  - pixels (15,20) and (10,24) give 0.
  - the same pixel with sel=1 gives 0.
  - reset mid-hold gives sel=0, confirm=0, highlight=0 next cycle.

Source files
------------

// File: rtl/menu_pkg.sv
// Shared definitions for the VGA menu selector: button indices, packed item
// rectangle layout, navigation enums and rectangle helpers.
package menu_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_OK    = 4;

    localparam int RECT_W     = 30;
    localparam int RECT_B_LSB = 0;
    localparam int RECT_R_LSB = 7;
    localparam int RECT_T_LSB = 15;
    localparam int RECT_L_LSB = 22;

    typedef struct packed {
        logic [7:0] l;
        logic [6:0] t;
        logic [7:0] r;
        logic [6:0] b;
    } rect_t;

    // Direction codes double as the button bit index; DIR_NONE means nothing held.
    typedef enum logic [2:0] {
        DIR_UP    = 3'd0,
        DIR_DOWN  = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_RIGHT = 3'd3,
        DIR_NONE  = 3'd4
    } dir_e;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    function automatic rect_t rect_unpack(input logic [RECT_W-1:0] v);
        rect_t r;
        r.l = v[RECT_L_LSB +: 8];
        r.t = v[RECT_T_LSB +: 7];
        r.r = v[RECT_R_LSB +: 8];
        r.b = v[RECT_B_LSB +: 7];
        return r;
    endfunction

    // Half-open test; a box with l>=r or t>=b can never satisfy both bounds.
    function automatic logic rect_hit(input rect_t r, input logic [7:0] x, input logic [6:0] y);
        return (x >= r.l) && (x < r.r) && (y >= r.t) && (y < r.b);
    endfunction

endpackage

// File: rtl/vga_menu_select_if.sv
// Bundle of controller inputs, item geometry, pixel position and selector outputs.
interface vga_menu_select_if #(parameter int NUM_ITEMS = 3) ();
    import menu_pkg::*;

    localparam int SW = $clog2(NUM_ITEMS);

    logic [7:0]                 buttons;
    logic                       fsm_en;
    logic [NUM_ITEMS*RECT_W-1:0] item_rects;
    logic                       pix_en;
    logic [7:0]                 x_adj;
    logic [6:0]                 y_adj;
    logic [SW-1:0]              sel;
    logic                       confirm;
    logic                       highlight;

    modport master (
        output buttons, fsm_en, item_rects, pix_en, x_adj, y_adj,
        input  sel, confirm, highlight
    );

    modport slave (
        input  buttons, fsm_en, item_rects, pix_en, x_adj, y_adj,
        output sel, confirm, highlight
    );

endinterface

// File: rtl/menu_nav_fsm.sv
// Cursor navigation: button edge detection, auto-repeat tracking of the
// highest-priority held direction, and the sel / confirm registers.
module menu_nav_fsm
    import menu_pkg::*;
#(
    parameter int NUM_ITEMS    = 3,
    parameter int COLS         = 3,
    parameter int WRAP         = 1,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [4:0]                   buttons,
    input  logic                         fsm_en,
    output logic [$clog2(NUM_ITEMS)-1:0] sel,
    output logic                         confirm
);

    localparam int SW      = $clog2(NUM_ITEMS);
    localparam int LAST    = NUM_ITEMS - 1;
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef logic [SW-1:0] sel_t;
    typedef logic [CW-1:0] cnt_t;

    // The first repeat lands on the same edge the count reaches REPEAT_DELAY-1.
    localparam cnt_t DELAY_TH = cnt_t'(REPEAT_DELAY - 2);
    localparam cnt_t RATE_TH  = cnt_t'(REPEAT_RATE - 1);

    logic [4:0]  btn_r;
    logic [4:0]  hist_r;
    sel_t        sel_r;
    sel_t        sel_n;
    logic        confirm_r;
    logic        confirm_n;
    rpt_state_e  state_r;
    rpt_state_e  state_n;
    dir_e        dir_r;
    dir_e        dir_n;
    cnt_t        cnt_r;
    cnt_t        cnt_n;

    logic [4:0]  rise_s;
    dir_e        top_s;
    logic        rise_top_s;
    logic        due_s;
    logic [3:0]  rpt_vec_s;
    logic [3:0]  move_s;

    function automatic sel_t move_right(input sel_t s);
        int si;
        si = int'(s);
        if (si < LAST)          return sel_t'(si + 1);
        else if (WRAP != 0)     return sel_t'(0);
        else                    return sel_t'(LAST);
    endfunction

    function automatic sel_t move_left(input sel_t s);
        int si;
        si = int'(s);
        if (si > 0)             return sel_t'(si - 1);
        else if (WRAP != 0)     return sel_t'(LAST);
        else                    return sel_t'(0);
    endfunction

    function automatic sel_t move_down(input sel_t s);
        int si;
        si = int'(s);
        if (si + COLS <= LAST)  return sel_t'(si + COLS);
        else if (WRAP != 0)     return sel_t'(si % COLS);
        else                    return s;
    endfunction

    // Upward wrap lands on the bottom-most item of the same column.
    function automatic sel_t move_up(input sel_t s);
        int si;
        int cand;
        si   = int'(s);
        cand = (LAST / COLS) * COLS + (si % COLS);
        if (cand > LAST) cand = cand - COLS;
        if (si >= COLS)         return sel_t'(si - COLS);
        else if (WRAP != 0)     return sel_t'(cand);
        else                    return s;
    endfunction

    assign rise_s     = btn_r & ~hist_r;
    assign rise_top_s = (top_s != DIR_NONE) && rise_s[top_s[1:0]];
    assign rpt_vec_s  = due_s ? (4'b0001 << top_s[1:0]) : 4'b0000;
    assign move_s     = rise_s[3:0] | rpt_vec_s;

    // Highest-priority held direction (up > down > left > right).
    always_comb begin
        top_s = DIR_NONE;
        if (btn_r[BTN_UP])          top_s = DIR_UP;
        else if (btn_r[BTN_DOWN])   top_s = DIR_DOWN;
        else if (btn_r[BTN_LEFT])   top_s = DIR_LEFT;
        else if (btn_r[BTN_RIGHT])  top_s = DIR_RIGHT;
        else                        top_s = DIR_NONE;
    end

    // Repeat tracker next state; a direction held without a fresh press is tracked but never repeats.
    always_comb begin
        state_n = state_r;
        dir_n   = dir_r;
        cnt_n   = cnt_r;
        due_s   = 1'b0;
        if (!fsm_en || (top_s == DIR_NONE)) begin
            state_n = RPT_IDLE;
            dir_n   = DIR_NONE;
            cnt_n   = cnt_t'(0);
        end else if (rise_top_s || (top_s != dir_r)) begin
            dir_n = top_s;
            cnt_n = cnt_t'(0);
            if (rise_top_s || (state_r != RPT_IDLE)) state_n = RPT_DELAY;
            else                                     state_n = RPT_IDLE;
        end else begin
            case (state_r)
                RPT_IDLE: begin
                    state_n = RPT_IDLE;
                end
                RPT_DELAY: begin
                    if (cnt_r == DELAY_TH) begin
                        due_s   = 1'b1;
                        cnt_n   = cnt_t'(0);
                        state_n = RPT_REPEAT;
                    end else begin
                        cnt_n = cnt_r + cnt_t'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (cnt_r == RATE_TH) begin
                        due_s = 1'b1;
                        cnt_n = cnt_t'(0);
                    end else begin
                        cnt_n = cnt_r + cnt_t'(1);
                    end
                end
                default: begin
                    state_n = RPT_IDLE;
                    cnt_n   = cnt_t'(0);
                end
            endcase
        end
    end

    // One action per cycle: confirm edge blocks movement, then direction priority.
    always_comb begin
        sel_n     = sel_r;
        confirm_n = 1'b0;
        if (!fsm_en)                 sel_n = sel_r;
        else if (rise_s[BTN_OK])     confirm_n = 1'b1;
        else if (move_s[BTN_UP])     sel_n = move_up(sel_r);
        else if (move_s[BTN_DOWN])   sel_n = move_down(sel_r);
        else if (move_s[BTN_LEFT])   sel_n = move_left(sel_r);
        else if (move_s[BTN_RIGHT])  sel_n = move_right(sel_r);
        else                         sel_n = sel_r;
    end

    // Button sampling/history and all navigation state.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_r     <= 5'b00000;
            hist_r    <= 5'b00000;
            sel_r     <= sel_t'(0);
            confirm_r <= 1'b0;
            state_r   <= RPT_IDLE;
            dir_r     <= DIR_NONE;
            cnt_r     <= cnt_t'(0);
        end else begin
            btn_r     <= buttons;
            hist_r    <= btn_r;
            sel_r     <= sel_n;
            confirm_r <= confirm_n;
            state_r   <= state_n;
            dir_r     <= dir_n;
            cnt_r     <= cnt_n;
        end
    end

    assign sel     = sel_r;
    assign confirm = confirm_r;

endmodule

// File: rtl/vga_menu_select.sv
// Menu selection engine top: navigation core plus the per-pixel highlight of
// the currently selected item's rectangle.
module vga_menu_select
    import menu_pkg::*;
#(
    parameter int NUM_ITEMS    = 3,
    parameter int COLS         = 3,
    parameter int WRAP         = 1,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    vga_menu_select_if.slave   bus
);

    localparam int SW = $clog2(NUM_ITEMS);

    logic [SW-1:0] sel_s;
    logic          confirm_s;
    rect_t         rects_s [NUM_ITEMS];
    rect_t         cur_rect_s;
    logic          hit_s;
    logic          highlight_r;
    logic          unused_btn_s;

    assign unused_btn_s = ^bus.buttons[7:5];

    menu_nav_fsm #(
        .NUM_ITEMS    (NUM_ITEMS),
        .COLS         (COLS),
        .WRAP         (WRAP),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_nav (
        .clk     (clk),
        .reset   (reset),
        .buttons (bus.buttons[4:0]),
        .fsm_en  (bus.fsm_en),
        .sel     (sel_s),
        .confirm (confirm_s)
    );

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_rect
        assign rects_s[i] = rect_unpack(bus.item_rects[i*RECT_W +: RECT_W]);
    end

    assign cur_rect_s = rects_s[sel_s];
    assign hit_s      = rect_hit(cur_rect_s, bus.x_adj, bus.y_adj);

    // Highlight captured on pixel strobes only, held between them.
    always_ff @(posedge clk) begin
        if (reset)            highlight_r <= 1'b0;
        else if (bus.pix_en)  highlight_r <= hit_s;
        else                  highlight_r <= highlight_r;
    end

    assign bus.sel       = sel_s;
    assign bus.confirm   = confirm_s;
    assign bus.highlight = highlight_r;

endmodule

// File: tb/tb_vga_menu_select.sv
// Directed bench for vga_menu_select: a wrapping instance and a clamping
// instance, NUM_ITEMS=5, COLS=3, REPEAT_DELAY=20, REPEAT_RATE=8.
module tb_vga_menu_select;
    import menu_pkg::*;

    localparam logic [7:0] BU  = 8'h01;
    localparam logic [7:0] BD  = 8'h02;
    localparam logic [7:0] BL  = 8'h04;
    localparam logic [7:0] BR  = 8'h08;
    localparam logic [7:0] BOK = 8'h10;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    vga_menu_select_if #(.NUM_ITEMS(5)) busw ();
    vga_menu_select_if #(.NUM_ITEMS(5)) busc ();

    vga_menu_select #(.NUM_ITEMS(5), .COLS(3), .WRAP(1), .REPEAT_DELAY(20), .REPEAT_RATE(8))
        dut_wrap (.clk(clk), .reset(reset), .bus(busw));

    vga_menu_select #(.NUM_ITEMS(5), .COLS(3), .WRAP(0), .REPEAT_DELAY(20), .REPEAT_RATE(8))
        dut_clamp (.clk(clk), .reset(reset), .bus(busc));

    always #5 clk = ~clk;

    function automatic logic [29:0] mk(input logic [7:0] l, input logic [6:0] t,
                                       input logic [7:0] r, input logic [6:0] b);
        return {l, t, r, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press for one sample, release; sel is updated when this returns.
    task automatic tap(input bit clamp, input logic [7:0] b);
        if (clamp) busc.buttons = b; else busw.buttons = b;
        step(1);
        if (clamp) busc.buttons = 8'h00; else busw.buttons = 8'h00;
        step(1);
    endtask

    task automatic pix(input logic [7:0] x, input logic [6:0] y);
        busw.x_adj  = x;
        busw.y_adj  = y;
        busw.pix_en = 1'b1;
        step(1);
        busw.pix_en = 1'b0;
    endtask

    initial begin
        int exp_sel;
        int pulses;
        int pulse_at;

        reset = 1'b1;
        busw.buttons = 8'h00; busw.fsm_en = 1'b1; busw.pix_en = 1'b0;
        busw.x_adj = 8'd0; busw.y_adj = 7'd0;
        busw.item_rects = {mk(8'd100, 7'd100, 8'd90, 7'd110), mk(8'd0, 7'd0, 8'd160, 7'd120),
                           mk(8'd50, 7'd10, 8'd50, 7'd20), mk(8'd30, 7'd40, 8'd50, 7'd60),
                           mk(8'd10, 7'd20, 8'd15, 7'd24)};
        busc.buttons = 8'h00; busc.fsm_en = 1'b1; busc.pix_en = 1'b0;
        busc.x_adj = 8'd0; busc.y_adj = 7'd0;
        busc.item_rects = busw.item_rects;

        step(3);
        check("rst_sel", 32'(busw.sel), 32'd0);
        check("rst_confirm", 32'(busw.confirm), 32'd0);
        check("rst_highlight", 32'(busw.highlight), 32'd0);
        reset = 1'b0;
        step(2);

        // Wrapping right walk and left wrap.
        tap(1'b0, BR); check("right1", 32'(busw.sel), 32'd1);
        tap(1'b0, BR); check("right2", 32'(busw.sel), 32'd2);
        tap(1'b0, BR); check("right3", 32'(busw.sel), 32'd3);
        tap(1'b0, BR); check("right4", 32'(busw.sel), 32'd4);
        tap(1'b0, BR); check("right_wrap", 32'(busw.sel), 32'd0);
        check("move_no_confirm", 32'(busw.confirm), 32'd0);
        tap(1'b0, BL); check("left_wrap", 32'(busw.sel), 32'd4);

        // Grid moves with wrap.
        tap(1'b0, BR); tap(1'b0, BR); check("to_sel1", 32'(busw.sel), 32'd1);
        tap(1'b0, BU); check("up_wrap_col1", 32'(busw.sel), 32'd4);
        tap(1'b0, BD); check("down_wrap_4", 32'(busw.sel), 32'd1);
        tap(1'b0, BR); tap(1'b0, BD); check("down_wrap_2", 32'(busw.sel), 32'd2);

        // Clamping instance.
        tap(1'b1, BL); check("clamp_left0", 32'(busc.sel), 32'd0);
        tap(1'b1, BU); check("clamp_up0", 32'(busc.sel), 32'd0);
        tap(1'b1, BR); tap(1'b1, BR); tap(1'b1, BR); tap(1'b1, BR);
        check("clamp_to4", 32'(busc.sel), 32'd4);
        tap(1'b1, BR); check("clamp_right4", 32'(busc.sel), 32'd4);
        tap(1'b1, BD); check("clamp_down4", 32'(busc.sel), 32'd4);

        // Auto-repeat: hold right from sel=0.
        tap(1'b0, BR); tap(1'b0, BR); tap(1'b0, BR);
        check("hold_start", 32'(busw.sel), 32'd0);
        busw.buttons = BR;
        exp_sel = 0;
        for (int k = 1; k <= 58; k++) begin
            step(1);
            if (k == 2 || k == 21 || k == 29 || k == 37 || k == 45 || k == 53)
                exp_sel = (exp_sel + 1) % 5;
            check($sformatf("hold_k%0d", k), 32'(busw.sel), 32'(exp_sel));
        end
        busw.buttons = 8'h00;
        step(3);
        check("hold_release", 32'(busw.sel), 32'd1);
        busw.buttons = BR;
        step(10);
        busw.buttons = 8'h00;
        step(3);
        check("repress_one_step", 32'(busw.sel), 32'd2);

        // Priority and confirm.
        tap(1'b0, BR); tap(1'b0, BR); check("to_sel4", 32'(busw.sel), 32'd4);
        tap(1'b0, BU | BR); check("up_beats_right", 32'(busw.sel), 32'd1);
        tap(1'b0, BOK | BR);
        check("ok_right_confirm", 32'(busw.confirm), 32'd1);
        check("ok_right_sel", 32'(busw.sel), 32'd1);
        step(1);
        check("confirm_one_cycle", 32'(busw.confirm), 32'd0);
        busw.buttons = BOK;
        pulses = 0; pulse_at = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (busw.confirm === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
        end
        busw.buttons = 8'h00;
        step(2);
        check("ok_hold_pulses", 32'(pulses), 32'd1);
        check("ok_latency", 32'(pulse_at), 32'd2);

        // Disabled navigation, and a button held across enabling.
        busw.fsm_en = 1'b0;
        tap(1'b0, BR); check("dis_sel_frozen", 32'(busw.sel), 32'd1);
        tap(1'b0, BOK); check("dis_no_confirm", 32'(busw.confirm), 32'd0);
        busw.buttons = BR;
        step(3);
        busw.fsm_en = 1'b1;
        step(30);
        check("held_over_enable", 32'(busw.sel), 32'd1);
        busw.buttons = 8'h00;
        step(2);
        tap(1'b0, BR); check("after_reenable", 32'(busw.sel), 32'd2);

        // Highlight hit tests.
        tap(1'b0, BL); tap(1'b0, BL); check("hl_sel0", 32'(busw.sel), 32'd0);
        pix(8'd10, 7'd20);  check("hl_topleft", 32'(busw.highlight), 32'd1);
        pix(8'd15, 7'd20);  check("hl_right_edge", 32'(busw.highlight), 32'd0);
        pix(8'd10, 7'd24);  check("hl_bottom_edge", 32'(busw.highlight), 32'd0);
        pix(8'd9, 7'd20);   check("hl_left_out", 32'(busw.highlight), 32'd0);
        pix(8'd14, 7'd23);  check("hl_inner_corner", 32'(busw.highlight), 32'd1);
        busw.x_adj = 8'd0; busw.y_adj = 7'd0;
        step(1);
        check("hl_hold", 32'(busw.highlight), 32'd1);
        tap(1'b0, BR);
        pix(8'd10, 7'd20);  check("hl_sel1_miss", 32'(busw.highlight), 32'd0);
        pix(8'd30, 7'd40);  check("hl_sel1_hit", 32'(busw.highlight), 32'd1);
        tap(1'b0, BR);
        pix(8'd50, 7'd15);  check("hl_empty_width", 32'(busw.highlight), 32'd0);
        tap(1'b0, BR);
        pix(8'd159, 7'd119); check("hl_full_corner", 32'(busw.highlight), 32'd1);
        tap(1'b0, BR);
        pix(8'd95, 7'd105); check("hl_inverted", 32'(busw.highlight), 32'd0);

        // Reset while a confirm is pending.
        tap(1'b0, BL);
        pix(8'd0, 7'd0);    check("pre_reset_hl", 32'(busw.highlight), 32'd1);
        busw.buttons = BOK | BR;
        step(1);
        reset = 1'b1;
        step(1);
        check("reset_sel", 32'(busw.sel), 32'd0);
        check("reset_confirm", 32'(busw.confirm), 32'd0);
        check("reset_highlight", 32'(busw.highlight), 32'd0);
        reset = 1'b0;
        busw.buttons = 8'h00;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
